// File: rtl/ede_frame_streamer.sv
// Captures one record of samples, then replays it as an edge-padded valid/ready
// stream so the downstream smoothing filter always sees a full window.
module ede_frame_streamer #(
  parameter int DW   = 10,
  parameter int N    = 2400,
  parameter int HALF = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          wr_drop,
  output logic          full,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [DW-1:0] o_data,
  output logic          o_first,
  output logic          o_last
);

  localparam int TOTAL = N + 2 * HALF;
  localparam int SIW   = $clog2(TOTAL);
  localparam int AW    = (N > 1) ? $clog2(N) : 1;
  localparam int WPW   = $clog2(N + 1);

  localparam logic [1:0] ST_CAPTURE = 2'd0;
  localparam logic [1:0] ST_STREAM  = 2'd1;
  localparam logic [1:0] ST_FINISH  = 2'd2;

  localparam logic [SIW-1:0] SI_LAST    = SIW'(TOTAL - 1);
  localparam logic [SIW-1:0] SI_HALF    = SIW'(HALF);
  localparam logic [SIW-1:0] SI_TAIL    = SIW'(N + HALF);
  localparam logic [AW-1:0]  ADDR_LAST  = AW'(N - 1);
  localparam logic [WPW-1:0] WP_FULL    = WPW'(N);

  logic [DW-1:0]  mem [0:N-1];
  logic [1:0]     state;
  logic [WPW-1:0] wp;
  logic [SIW-1:0] si;
  logic [SIW-1:0] si_nx;
  logic [AW-1:0]  rd_addr;
  logic [DW-1:0]  ram_q;
  logic           wr_acc;
  logic           xfer;

  assign full    = (wp == WP_FULL);
  assign wr_acc  = wr_en && (state == ST_CAPTURE) && !full;
  assign xfer    = o_valid && o_ready;
  assign busy    = (state == ST_STREAM);
  assign done    = (state == ST_FINISH);
  assign o_data  = o_valid ? ram_q : '0;
  assign o_first = o_valid && (si == '0);
  assign o_last  = o_valid && (si == SI_LAST);

  // Address the RAM with the index that will be presented next cycle, so the
  // registered read lines up with si and simply repeats while stalled.
  assign si_nx = (xfer && (si != SI_LAST)) ? si + SIW'(1) : si;

  always_comb begin
    rd_addr = '0;
    if (si_nx < SI_HALF) begin
      rd_addr = '0;
    end else if (si_nx < SI_TAIL) begin
      rd_addr = AW'(si_nx - SI_HALF);
    end else begin
      rd_addr = ADDR_LAST;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wp[AW-1:0]] <= wr_data;
    end
    ram_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_CAPTURE;
      wp      <= '0;
      si      <= '0;
      o_valid <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= wr_en && !wr_acc;
      case (state)
        ST_CAPTURE: begin
          if (wr_acc) begin
            wp <= wp + WPW'(1);
          end
          if (start && full) begin
            state   <= ST_STREAM;
            si      <= '0;
            o_valid <= 1'b0;
          end
        end
        ST_STREAM: begin
          // First STREAM cycle only primes the RAM read.
          if (!o_valid) begin
            o_valid <= 1'b1;
          end else if (o_ready) begin
            if (si == SI_LAST) begin
              state   <= ST_FINISH;
              o_valid <= 1'b0;
              wp      <= '0;
            end else begin
              si <= si + SIW'(1);
            end
          end
        end
        ST_FINISH: begin
          state <= ST_CAPTURE;
          wp    <= '0;
        end
        default: begin
          state   <= ST_CAPTURE;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ede_frame_streamer.sv
// Scoreboard bench for ede_frame_streamer: the stimulus thread predicts the
// padded stream from the captured record, a monitor pops and compares transfers.
module tb_ede_frame_streamer;

  localparam int DW    = 10;
  localparam int N     = 2400;
  localparam int HALF  = 7;
  localparam int TOTAL = N + 2 * HALF;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          wr_drop;
  logic          full;
  logic          start;
  logic          busy;
  logic          done;
  logic          o_valid;
  logic          o_ready;
  logic [DW-1:0] o_data;
  logic          o_first;
  logic          o_last;

  typedef struct {
    int data;
    bit first;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   ref_buf[N];
  int   model_wp;
  bit   model_busy;
  int   check_count;
  int   pass_count;
  int   xfer_count;
  bit   done_exp;
  int   ready_mode;

  ede_frame_streamer #(.DW(DW), .N(N), .HALF(HALF)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .wr_drop(wr_drop), .full(full), .start(start), .busy(busy),
    .done(done), .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
    .o_first(o_first), .o_last(o_last)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    check_count++;
    if (actual == expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Downstream ready: always high, or a fair coin each cycle.
  initial begin
    o_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      o_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: compares whatever is presented against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t item;
    if (reset) begin
      done_exp = 1'b0;
    end else begin
      checkOutput("done", done, done_exp);
      if (done_exp) begin
        checkOutput("busy_at_done", busy, 0);
        checkOutput("full_at_done", full, 0);
        checkOutput("valid_at_done", o_valid, 0);
      end
      done_exp = 1'b0;
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_valid", 1, 0);
        end else begin
          checkOutput("o_data", o_data, exp_q[0].data);
          checkOutput("o_first", o_first, exp_q[0].first);
          checkOutput("o_last", o_last, exp_q[0].last);
          if (o_ready) begin
            item = exp_q.pop_front();
            xfer_count++;
            done_exp = item.last;
          end
        end
      end
    end
  end

  task automatic push_stream();
    exp_t e;
    for (int k = 0; k < TOTAL; k++) begin
      if (k < HALF) e.data = ref_buf[0];
      else if (k < N + HALF) e.data = ref_buf[k - HALF];
      else e.data = ref_buf[N - 1];
      e.first = (k == 0);
      e.last  = (k == TOTAL - 1);
      exp_q.push_back(e);
    end
  endtask

  // One clock of stimulus; entered and left 1ns after a rising edge.
  task automatic applyStimulus(input bit we, input logic [DW-1:0] d, input bit st);
    bit exp_drop, exp_start;
    exp_drop  = we && (model_busy || model_wp == N);
    exp_start = st && !model_busy && model_wp == N;
    wr_en   = we;
    wr_data = d;
    start   = st;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    start = 1'b0;
    if (we && !exp_drop) begin
      ref_buf[model_wp] = int'(d);
      model_wp++;
    end
    if (exp_start) begin
      model_busy = 1'b1;
      xfer_count = 0;
      push_stream();
    end
    checkOutput("wr_drop", wr_drop, exp_drop);
    checkOutput("busy", busy, model_busy);
    if (!model_busy) checkOutput("full", full, model_wp == N);
  endtask

  task automatic fill(input int count, input bit ramp);
    for (int i = 0; i < count; i++)
      applyStimulus(1'b1, ramp ? DW'(model_wp) : DW'($urandom), 1'b0);
  endtask

  task automatic start_stream(input bit exp_ok);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("valid_latency", o_valid, exp_ok);
  endtask

  task automatic wait_done();
    for (int c = 0; c < 20000; c++) begin
      if (done) break;
      @(posedge clk);
      #1;
    end
    checkOutput("done_seen", done, 1);
    checkOutput("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    model_busy = 1'b0;
    model_wp   = 0;
    applyStimulus(1'b0, '0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = '0; start = 1'b0; ready_mode = 0;
    model_wp = 0; model_busy = 1'b0; check_count = 0; pass_count = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_full", full, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_valid", o_valid, 0);
    checkOutput("reset_first", o_first, 0);
    checkOutput("reset_last", o_last, 0);
    checkOutput("reset_drop", wr_drop, 0);
    checkOutput("reset_data", o_data, 0);
    reset = 1'b0;

    $display("[TB] ramp fill, ready held high");
    fill(N, 1'b1);
    start_stream(1'b1);
    wait_done();

    $display("[TB] ramp fill, random backpressure");
    ready_mode = 1;
    fill(N, 1'b1);
    start_stream(1'b1);
    wait_done();
    ready_mode = 0;

    $display("[TB] overflow and start racing the last write");
    fill(N - 1, 1'b0);
    applyStimulus(1'b1, DW'($urandom), 1'b1);
    applyStimulus(1'b1, DW'(ref_buf[N - 1] + 1), 1'b0);
    start_stream(1'b1);
    wait_done();

    $display("[TB] premature start");
    fill(100, 1'b0);
    start_stream(1'b0);
    repeat (3) applyStimulus(1'b0, '0, 1'b0);
    fill(N - 100, 1'b0);
    start_stream(1'b1);
    wait_done();

    $display("[TB] writes during stream");
    ready_mode = 1;
    fill(N, 1'b0);
    start_stream(1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, DW'($urandom), 1'b0);
    wait_done();
    fill(N, 1'b0);
    start_stream(1'b1);
    wait_done();
    ready_mode = 0;

    $display("[TB] reset mid-stream");
    fill(N, 1'b0);
    start_stream(1'b1);
    for (int c = 0; c < 5000; c++) begin
      if (xfer_count >= 500) break;
      @(posedge clk);
      #1;
    end
    checkOutput("reached_500", xfer_count, 500);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_valid", o_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_done", done, 0);
    reset = 1'b0;
    exp_q.delete();
    model_wp   = 0;
    model_busy = 1'b0;
    ready_mode = 1;
    fill(N, 1'b1);
    start_stream(1'b1);
    wait_done();

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/ede_frame_streamer.md
# ede_frame_streamer

Transmit side of the waveform smoothing path. Captures one 2400-sample record of 10-bit samples into an internal buffer, then replays it as a valid/ready stream to the 15-tap triangular smoothing filter. The stream is edge-padded: 7 copies of the first sample, the full record, then 7 copies of the last sample. The filter therefore sees a full window at every output position without any boundary logic of its own.

## Interface
- `DW`, default 10: sample width in bits.
- `N`, default 2400: samples per record. Must be at least 2.
- `HALF`, default 7: pad length at each end, equal to (taps-1)/2.
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: synchronous, active-high.
- `wr_en`, input, 1: capture strobe for `wr_data`.
- `wr_data`, input, DW: incoming sample.
- `wr_drop`, output, 1: one-cycle pulse when a `wr_en` is refused.
- `full`, output, 1: a complete record is buffered.
- `start`, input, 1: request to stream the buffered record.
- `busy`, output, 1: streaming in progress.
- `done`, output, 1: one-cycle pulse after the final transfer.
- `o_valid`, output, 1: `o_data` is valid.
- `o_ready`, input, 1: downstream accepts the sample.
- `o_data`, output, DW: streamed sample.
- `o_first`, output, 1: marks stream index 0.
- `o_last`, output, 1: marks stream index N+2·HALF−1.

## Operation
- Storage: N×DW buffer, write pointer `wp` (0..N), stream index `si` (0..N+2·HALF−1; 12 bits for the defaults).
- FSM states:
  - CAPTURE:
    - `wr_en` with `wp`<N: writes `buf[wp]` and increments `wp`.
    - `wp`=N: `full`=1.
    - `start` with `full`=1: go to STREAM, `si`=0.
    - `start` with `full`=0: ignored.
  - STREAM: emits sample `si`:
    - `si`<HALF: `buf[0]`.
    - HALF≤`si`<N+HALF: `buf[si−HALF]`.
    - `si`≥N+HALF: `buf[N−1]`.
    - `si` advances only on a transfer (`o_valid`&&`o_ready`).
    - Transfer at `si`=N+2·HALF−1: go to FINISH.
  - FINISH: one cycle.
    - Asserts `done`.
    - Clears `wp` to 0 and `full` to 0. The record is consumed and a new capture is required.
    - Returns to CAPTURE.
- `wr_en` is refused, with a `wr_drop` pulse the same cycle as registered output, when:
  - in CAPTURE with `wp`=N, or
  - in STREAM or FINISH.
- Refused samples are never written.
- `start` during STREAM or FINISH is ignored. There is no queuing.
- Backpressure: while `o_valid`=1 and `o_ready`=0, `o_data`, `o_first` and `o_last` hold stable and `o_valid` stays high. No sample is skipped or duplicated.
- `o_first` and `o_last` are valid only while `o_valid`=1. They are 0 otherwise.
- The buffer is not cleared by reset. Its contents are unobservable until rewritten.

## Timing
- Reset values: `wp`=0, state CAPTURE, `full`=0, `busy`=0, `done`=0, `o_valid`=0, `o_first`=0, `o_last`=0, `wr_drop`=0, `o_data`=0.
- `full` rises on the cycle after the Nth accepted write.
- Start latency:
  - `start` sampled at edge T with `full`=1 gives `busy`=1 from T+1.
  - The first `o_valid` occurs at T+2, allowing one synchronous RAM read plus the output register.
- Throughput: one sample per cycle while `o_ready` is held high. With `o_ready` always high, the stream is N+2·HALF (2414) consecutive valid cycles.
- `done` pulses on the cycle after the final transfer. `busy`, `full` and `o_valid` are 0 on that same cycle.
- `wr_en` accepted again from the cycle after `done`.
- Reset mid-stream: on the next edge, all outputs take their reset values, `wp`=0, and the FSM returns to CAPTURE. No `done` is issued.
- A simultaneous `wr_en` and `start` in CAPTURE with `wp`=N−1:
  - the write is accepted;
  - `start` is ignored, because `full` was 0 when sampled.

## Test plan
- Fill: write `buf[i]`=i for i=0..2399 with `o_ready`=1, then pulse `start`.
  - Required: 2414 transfers, values 0×8 (7 pads plus the real sample 0), then 1..2398, then 2399×8.
  - Required: `o_first` only on transfer 0, `o_last` only on transfer 2413.
  - Required: `done` one cycle after the last transfer.
- Backpressure: same record, `o_ready` driven by a pseudo-random 50% pattern.
  - Required: identical 2414-value sequence.
  - Required: `o_data` stable during every stall.
- Overflow: write 2401 samples.
  - Required: `wr_drop` pulse on the 2401st write.
  - Required: streamed data ends with value 2399, not the dropped sample.
- Premature start: `start` after 100 writes.
  - Required: `busy` stays 0 and `o_valid` stays 0.
  - Then complete the fill and start: a normal stream of 2414 samples.
- Write during stream: `wr_en` pulses while `busy`=1.
  - Required: a `wr_drop` pulse for each.
  - Required: after `done`, `full`=0 and `wp` restarts at 0; a new 2400-sample fill is required before the next stream.
- Reset mid-stream: assert `reset` at transfer 500.
  - Required: next cycle `o_valid`=0, `busy`=0, `full`=0, and no `done`.
  - Required: a subsequent full fill and start streams correctly.
